// File: rtl/alu_op_driver.sv
// Sequential initiator for a combinational ALU: accepts single or sweep requests,
// drives registered operands/select, waits a fixed settle time and returns captured results.
module alu_op_driver #(
    parameter int WIDTH         = 8,
    parameter int SEL_W         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_sweep,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SEL_W-1:0] rsp_sel,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic             rsp_last,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic             sweep_r,     sweep_s;
    logic [WIDTH-1:0] alu_a_r,     alu_a_s;
    logic [WIDTH-1:0] alu_b_r,     alu_b_s;
    logic [SEL_W-1:0] alu_sel_r,   alu_sel_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [SEL_W-1:0] rsp_sel_r,   rsp_sel_s;
    logic [WIDTH-1:0] rsp_out_r,   rsp_out_s;
    logic             rsp_carry_r, rsp_carry_s;
    logic             rsp_last_r,  rsp_last_s;
    logic             req_ready_r, req_ready_s;
    logic             busy_r,      busy_s;
    logic [15:0]      op_count_r,  op_count_s;

    // Next-state and next-output logic; every register holds unless a transition says otherwise.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        sweep_s     = sweep_r;
        alu_a_s     = alu_a_r;
        alu_b_s     = alu_b_r;
        alu_sel_s   = alu_sel_r;
        rsp_valid_s = rsp_valid_r;
        rsp_sel_s   = rsp_sel_r;
        rsp_out_s   = rsp_out_r;
        rsp_carry_s = rsp_carry_r;
        rsp_last_s  = rsp_last_r;
        op_count_s  = op_count_r;

        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    alu_a_s   = req_a;
                    alu_b_s   = req_b;
                    alu_sel_s = req_sweep ? {SEL_W{1'b0}} : req_sel;
                    sweep_s   = req_sweep;
                    cnt_s     = CNT_LOAD;
                    state_s   = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // The edge that sees cnt_r==1 is the SETTLE_CYCLES-th since alu_* last moved.
                if (cnt_r == CNT_ONE) begin
                    rsp_out_s   = alu_out;
                    rsp_carry_s = alu_carry;
                    rsp_sel_s   = alu_sel_r;
                    rsp_last_s  = !sweep_r || (alu_sel_r == SEL_LAST);
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    op_count_s  = op_count_r + 16'd1;
                    rsp_valid_s = 1'b0;
                    if (rsp_last_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        alu_sel_s = alu_sel_r + SEL_ONE;
                        cnt_s     = CNT_LOAD;
                        state_s   = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase

        // Ready/busy are registered from the next state, so ready never rises in a handshake cycle.
        req_ready_s = (state_s == ST_IDLE);
        busy_s      = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            sweep_r     <= 1'b0;
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_sel_r   <= {SEL_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_sel_r   <= {SEL_W{1'b0}};
            rsp_out_r   <= {WIDTH{1'b0}};
            rsp_carry_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            op_count_r  <= 16'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sweep_r     <= sweep_s;
            alu_a_r     <= alu_a_s;
            alu_b_r     <= alu_b_s;
            alu_sel_r   <= alu_sel_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_sel_r   <= rsp_sel_s;
            rsp_out_r   <= rsp_out_s;
            rsp_carry_r <= rsp_carry_s;
            rsp_last_r  <= rsp_last_s;
            req_ready_r <= req_ready_s;
            busy_r      <= busy_s;
            op_count_r  <= op_count_s;
        end
    end

    assign req_ready = req_ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_sel   = rsp_sel_r;
    assign rsp_out   = rsp_out_r;
    assign rsp_carry = rsp_carry_r;
    assign rsp_last  = rsp_last_r;
    assign busy      = busy_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: table vectors, hand-written corner sequences and random requests
// scored against a request-level model; a second instance checks a slow ALU with SETTLE_CYCLES=3.
module tb_alu_op_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       req_valid, req_ready, req_sweep;
    logic [7:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_out;
    logic [3:0] req_sel, alu_sel, rsp_sel;
    logic       alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_last, busy;
    logic [15:0] op_count;

    logic       s3_req_valid, s3_req_ready, s3_req_sweep;
    logic [7:0] s3_req_a, s3_req_b, s3_alu_a, s3_alu_b, s3_alu_out, s3_rsp_out;
    logic [3:0] s3_req_sel, s3_alu_sel, s3_rsp_sel;
    logic       s3_alu_carry, s3_rsp_valid, s3_rsp_ready, s3_rsp_carry, s3_rsp_last, s3_busy;
    logic [15:0] s3_op_count;

    int vectors    = 0;
    int miscompares = 0;
    int exp_ops    = 0;

    // Reference ALU: returns {carry, result}.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        case (sel)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {a, 1'b0};
            4'd3:    return {a[0], 1'b0, a[7:1]};
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a | b};
            4'd6:    return {1'b0, a ^ b};
            4'd7:    return {1'b0, ~a};
            4'd8:    return {1'b0, b};
            4'd9:    return {1'b0, a};
            4'd10:   return {1'b0, a} + 9'd1;
            4'd11:   return {1'b0, a} - 9'd1;
            4'd12:   return {1'b0, a[6:0], a[7]};
            4'd13:   return {1'b0, a[0], a[7:1]};
            4'd14:   return {1'b0, a} + {1'b0, b} + 9'd1;
            default: return {1'b0, ~(a & b)};
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

    // Slow ALU: result appears two clocks after its inputs change.
    logic [8:0] s3_pipe1, s3_pipe2;
    always_ff @(posedge clk) begin
        s3_pipe1 <= alu_fn(s3_alu_a, s3_alu_b, s3_alu_sel);
        s3_pipe2 <= s3_pipe1;
    end
    assign {s3_alu_carry, s3_alu_out} = s3_pipe2;

    alu_op_driver #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_sweep(req_sweep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel), .rsp_out(rsp_out),
        .rsp_carry(rsp_carry), .rsp_last(rsp_last), .busy(busy), .op_count(op_count)
    );

    alu_op_driver #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(s3_req_valid), .req_ready(s3_req_ready), .req_a(s3_req_a), .req_b(s3_req_b),
        .req_sel(s3_req_sel), .req_sweep(s3_req_sweep),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_sel(s3_alu_sel), .alu_out(s3_alu_out),
        .alu_carry(s3_alu_carry),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_sel(s3_rsp_sel), .rsp_out(s3_rsp_out),
        .rsp_carry(s3_rsp_carry), .rsp_last(s3_rsp_last), .busy(s3_busy), .op_count(s3_op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request on the main instance; responses checked against the model as they are consumed.
    task automatic run_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                           input logic sweep, input int stall_pct);
        int n_exp;
        int k;
        int cyc;
        logic [8:0] r;
        logic [3:0] esel;
        cyc = 0;
        while (!req_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_sweep = sweep; rsp_ready = 1'b0;
        @(negedge clk);
        check("accept_busy", busy, 1);
        n_exp = sweep ? 16 : 1;
        k = 0;
        cyc = 0;
        while (k < n_exp && cyc < 1000) begin
            req_valid = 1'($urandom_range(1));
            req_a = 8'($urandom); req_b = 8'($urandom);
            req_sel = 4'($urandom); req_sweep = 1'($urandom);
            rsp_ready = ($urandom_range(99) >= stall_pct);
            if (rsp_valid && rsp_ready) begin
                esel = sweep ? 4'(k) : sel;
                r = alu_fn(a, b, esel);
                check("rsp_sel", rsp_sel, esel);
                check("rsp_out", rsp_out, r[7:0]);
                check("rsp_carry", rsp_carry, r[8]);
                check("rsp_last", rsp_last, (!sweep || k == 15));
                check("alu_a_hold", alu_a, a);
                check("alu_b_hold", alu_b, b);
                check("alu_sel", alu_sel, esel);
                check("req_ready_busy", req_ready, 0);
                k++;
                exp_ops++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rsp_count", k, n_exp);
        if (stall_pct == 0) check("rsp_timing", cyc, 2 * n_exp);
        check("idle_after", busy, 0);
        check("ready_after", req_ready, 1);
        check("op_count", op_count, 16'(exp_ops));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_out;
        logic       exp_carry;
    } vec_t;

    vec_t tbl[9];

    logic [7:0] hold_out;
    logic       found;
    int         cyc;
    logic [7:0] s3_a[4];
    logic [7:0] s3_b[4];
    logic [3:0] s3_s[4];
    logic [8:0] s3_r;

    initial begin
        tbl[0] = '{8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0};
        tbl[1] = '{8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1};
        tbl[2] = '{8'h0A, 8'h02, 4'd1, 8'h08, 1'b0};
        tbl[3] = '{8'h0A, 8'h02, 4'd2, 8'h14, 1'b0};
        tbl[4] = '{8'h0A, 8'h02, 4'd3, 8'h05, 1'b0};
        tbl[5] = '{8'h03, 8'h05, 4'd1, 8'hFE, 1'b1};
        tbl[6] = '{8'hF0, 8'h0F, 4'd4, 8'h00, 1'b0};
        tbl[7] = '{8'hF0, 8'h0F, 4'd5, 8'hFF, 1'b0};
        tbl[8] = '{8'h81, 8'h00, 4'd2, 8'h02, 1'b1};

        rst = 1'b1;
        req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_sel = 4'h0; req_sweep = 1'b0; rsp_ready = 1'b0;
        s3_req_valid = 1'b0; s3_req_a = 8'h00; s3_req_b = 8'h00; s3_req_sel = 4'h0;
        s3_req_sweep = 1'b0; s3_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_op_count", op_count, 0);
        check("rst_s3_req_ready", s3_req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // Single op latency, then response held under back-pressure.
        req_valid = 1'b1; req_a = 8'h0A; req_b = 8'h02; req_sel = 4'd0; req_sweep = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("settle_no_rsp", rsp_valid, 0);
        check("drive_alu_a", alu_a, 8'h0A);
        check("drive_alu_b", alu_b, 8'h02);
        @(negedge clk);
        check("lat_rsp_valid", rsp_valid, 1);
        check("lat_rsp_out", rsp_out, 8'h0C);
        check("lat_rsp_carry", rsp_carry, 0);
        check("lat_rsp_last", rsp_last, 1);
        hold_out = rsp_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_out", rsp_out, hold_out);
            check("stall_alu_a", alu_a, 8'h0A);
            check("stall_alu_sel", alu_sel, 0);
            check("stall_op_count", op_count, 0);
            check("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_ops = 1;
        check("hs_rsp_valid", rsp_valid, 0);
        check("hs_op_count", op_count, 1);
        check("hs_req_ready", req_ready, 1);

        // Table of single operations with hand-computed results.
        for (int i = 0; i < 9; i++) begin
            cyc = 0;
            while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
            req_valid = 1'b1; req_a = tbl[i].a; req_b = tbl[i].b; req_sel = tbl[i].sel; req_sweep = 1'b0;
            @(negedge clk);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            cyc = 0;
            while (!rsp_valid && cyc < 10) begin @(negedge clk); cyc++; end
            check("tbl_valid", rsp_valid, 1);
            check("tbl_out", rsp_out, tbl[i].exp_out);
            check("tbl_carry", rsp_carry, tbl[i].exp_carry);
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_ops++;
            check("tbl_op_count", op_count, 16'(exp_ops));
        end

        // Full sweep with no back-pressure.
        run_req(8'h0A, 8'h02, 4'd9, 1'b1, 0);

        // Reset while sel 7 of a sweep is waiting.
        req_valid = 1'b1; req_a = 8'h33; req_b = 8'h44; req_sel = 4'd0; req_sweep = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid && rsp_sel == 4'd7) begin
                found = 1'b1;
                rsp_ready = 1'b0;
            end
        end
        check("abort_reached_sel7", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_sel", alu_sel, 0);
        check("abort_op_count", op_count, 0);
        check("abort_busy", busy, 0);
        check("abort_req_ready", req_ready, 0);
        rst = 1'b0;
        exp_ops = 0;
        @(negedge clk);
        check("abort_ready_after", req_ready, 1);

        // Random requests with random back-pressure.
        for (int i = 0; i < 30; i++) begin
            run_req(8'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(7) == 0),
                    int'($urandom_range(60)));
        end

        // Slow ALU, three settle edges, request held high across handshakes.
        s3_a[0] = 8'h0A; s3_b[0] = 8'h02; s3_s[0] = 4'd0;
        s3_a[1] = 8'hF6; s3_b[1] = 8'h0A; s3_s[1] = 4'd0;
        s3_a[2] = 8'h81; s3_b[2] = 8'h00; s3_s[2] = 4'd2;
        s3_a[3] = 8'h03; s3_b[3] = 8'h05; s3_s[3] = 4'd1;
        s3_rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc = 0;
            while (!s3_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
            check("s3_ready", s3_req_ready, 1);
            s3_req_valid = 1'b1; s3_req_a = s3_a[j]; s3_req_b = s3_b[j]; s3_req_sel = s3_s[j];
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                @(negedge clk);
                check("s3_early_valid", s3_rsp_valid, 0);
            end
            @(negedge clk);
            s3_r = alu_fn(s3_a[j], s3_b[j], s3_s[j]);
            check("s3_valid", s3_rsp_valid, 1);
            check("s3_out", s3_rsp_out, s3_r[7:0]);
            check("s3_carry", s3_rsp_carry, s3_r[8]);
            check("s3_hs_ready", s3_req_ready, 0);
            @(negedge clk);
            check("s3_after_valid", s3_rsp_valid, 0);
            check("s3_no_accept", s3_busy, 0);
            check("s3_ready_next", s3_req_ready, 1);
        end
        s3_req_valid = 1'b0;
        s3_rsp_ready = 1'b0;
        check("s3_op_count", s3_op_count, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
